// File: rtl/jtkicker_gfx_arb.sv
// jtkicker_gfx_arb: shares one SDRAM graphics read slot between the scroll and object fetchers,
// each behind a private address-tagged one-word buffer.
module jtkicker_gfx_arb #(
  parameter int AW = 13,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
  output logic          mem_cs,
  output logic [AW:0]   mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_ok,
  output logic          timeout
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0, WAIT = 1'b1;
  logic [0:0]    r_state;
  logic [AW-1:0] r_tag_s, r_tag_o, r_itag;
  logic [DW-1:0] r_buf_s, r_buf_o;
  logic          r_valid_s, r_valid_o, r_last, r_sel;
  logic [CW-1:0] r_cnt;
  logic          w_hit_s, w_hit_o, w_miss_s, w_miss_o, w_sel, w_expire;
  logic [AW-1:0] w_iaddr;
  always_comb begin
    w_hit_s  = r_valid_s && r_tag_s == scr_addr;
    w_hit_o  = r_valid_o && r_tag_o == obj_addr;
    w_miss_s = scr_cs && !w_hit_s;
    w_miss_o = obj_cs && !w_hit_o;
    // on a tie the requester not served last time wins
    w_sel    = w_miss_s && w_miss_o ? !r_last : w_miss_o;
    w_iaddr  = w_sel ? obj_addr : scr_addr;
    w_expire = TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1);
  end
  assign scr_ok   = scr_cs && w_hit_s;
  assign obj_ok   = obj_cs && w_hit_o;
  assign scr_data = r_buf_s;
  assign obj_data = r_buf_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      mem_cs    <= 1'b0;
      mem_addr  <= '0;
      r_tag_s   <= '0;
      r_tag_o   <= '0;
      r_itag    <= '0;
      r_buf_s   <= '0;
      r_buf_o   <= '0;
      r_valid_s <= 1'b0;
      r_valid_o <= 1'b0;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_cnt     <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (flush) begin
        r_valid_s <= 1'b0;
        r_valid_o <= 1'b0;
      end
      if (r_state == IDLE) begin
        if (w_miss_s || w_miss_o) begin
          mem_cs   <= 1'b1;
          mem_addr <= {w_sel, w_iaddr};
          r_itag   <= w_iaddr;
          r_last   <= w_sel;
          r_sel    <= w_sel;
          r_cnt    <= '0;
          r_state  <= WAIT;
        end
      end else if (mem_ok) begin
        // the capture is stored under the issued tag and overrides a simultaneous flush
        mem_cs  <= 1'b0;
        r_state <= IDLE;
        if (r_sel) begin
          r_buf_o   <= mem_data;
          r_tag_o   <= r_itag;
          r_valid_o <= 1'b1;
        end else begin
          r_buf_s   <= mem_data;
          r_tag_s   <= r_itag;
          r_valid_s <= 1'b1;
        end
      end else if (w_expire) begin
        mem_cs  <= 1'b0;
        timeout <= 1'b1;
        r_state <= IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtkicker_gfx_arb.sv
// tb_jtkicker_gfx_arb: directed scenarios plus a randomized run against a transaction-level buffer model.
module tb_jtkicker_gfx_arb;
  localparam int AW = 13, DW = 32, TO = 8;
  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic          scr_cs = 1'b0, obj_cs = 1'b0;
  logic [AW-1:0] scr_addr = '0, obj_addr = '0;
  logic [DW-1:0] scr_data, obj_data, mem_data;
  logic          scr_ok, obj_ok, mem_cs, mem_ok, timeout;
  logic [AW:0]   mem_addr;
  bit            rsp_en = 1'b0;
  logic          a_ok = 1'b0, m_ok = 1'b0;
  logic [DW-1:0] a_data = '0, m_data = '0;
  int            lat = 2, rcnt = 0;
  int            errs = 0, checks = 0;
  bit            mv [2];
  logic [AW-1:0] mt [2];
  bit            pcs = 1'b0;
  logic [AW:0]   issued [$];

  always #5 clk = ~clk;
  assign mem_ok   = rsp_en ? a_ok : m_ok;
  assign mem_data = rsp_en ? a_data : m_data;

  jtkicker_gfx_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok),
    .timeout(timeout)
  );

  function automatic logic [31:0] f(input logic [13:0] a);
    return {a, 4'h5, a} ^ 32'h3C96_A50F;
  endfunction

  // SDRAM model: answers each request after lat cycles with data derived from its address
  always @(negedge clk) begin
    a_ok = 1'b0;
    if (mem_cs) begin
      if (rcnt >= lat) begin
        a_ok = 1'b1;
        a_data = f(mem_addr);
        rcnt = 0;
      end else rcnt++;
    end else rcnt = 0;
  end

  // buffer model: a completed read makes its region's word valid under the issued address
  always @(posedge clk) begin
    if (mem_cs && !pcs) issued.push_back(mem_addr);
    pcs = mem_cs;
    if (rst) begin
      mv[0] = 1'b0;
      mv[1] = 1'b0;
    end else begin
      if (flush) begin
        mv[0] = 1'b0;
        mv[1] = 1'b0;
      end
      if (mem_cs && mem_ok) begin
        mv[mem_addr[AW]] = 1'b1;
        mt[mem_addr[AW]] = mem_addr[AW-1:0];
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0; m_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = mem_cs;
    end
  endtask

  task automatic wait_ok(input bit s, input bit o, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (!s || scr_ok) && (!o || obj_ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scr_cs = 1'b1; scr_addr = '0; obj_cs = 1'b1; obj_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (mem_cs !== 1'b0 || mem_addr !== '0) begin errs++; $display("FAIL reset_mem: mem_cs=%b mem_addr=%h want 0/0", mem_cs, mem_addr); end
    checks++; if (scr_ok !== 1'b0 || obj_ok !== 1'b0) begin errs++; $display("FAIL reset_ok: scr_ok=%b obj_ok=%b want 0/0", scr_ok, obj_ok); end
    checks++; if (scr_data !== '0 || obj_data !== '0 || timeout !== 1'b0) begin errs++; $display("FAIL reset_data: scr=%h obj=%h to=%b want 0", scr_data, obj_data, timeout); end
    scr_cs = 1'b0; obj_cs = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit got, bad;
    rsp_en = 1'b0;
    do_reset();
    scr_cs = 1'b1; scr_addr = 13'h0123;
    wait_cs(got);
    checks++; if (!got || mem_addr !== 14'h0123) begin errs++; $display("FAIL basic_issue: got=%b mem_addr=%h want 0123", got, mem_addr); end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_cs !== 1'b1 || scr_ok !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errs++; $display("FAIL basic_hold: mem_cs=%b scr_ok=%b want 1/0 during wait", mem_cs, scr_ok); end
    m_ok = 1'b1; m_data = 32'hDEADBEEF;
    @(negedge clk);
    m_ok = 1'b0;
    checks++; if (scr_ok !== 1'b1 || scr_data !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_hit: scr_ok=%b data=%h want 1/deadbeef", scr_ok, scr_data); end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_cs !== 1'b0 || scr_ok !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errs++; $display("FAIL basic_norefetch: mem_cs=%b scr_ok=%b want 0/1", mem_cs, scr_ok); end
    scr_cs = 1'b0;
    #1;
    checks++; if (scr_ok !== 1'b0) begin errs++; $display("FAIL basic_cs_low: scr_ok=%b want 0", scr_ok); end
    @(negedge clk);
    scr_cs = 1'b1;
    #1;
    checks++; if (scr_ok !== 1'b1 || scr_data !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_reassert: scr_ok=%b data=%h want 1/deadbeef", scr_ok, scr_data); end
    @(negedge clk);
    checks++; if (mem_cs !== 1'b0) begin errs++; $display("FAIL basic_reassert_mem: mem_cs=%b want 0", mem_cs); end
  endtask

  task automatic test_tie();
    bit got;
    int b;
    rsp_en = 1'b1; lat = 2;
    do_reset();
    b = issued.size();
    scr_cs = 1'b1; scr_addr = 13'h0010; obj_cs = 1'b1; obj_addr = 13'h0020;
    wait_ok(1'b1, 1'b1, got);
    checks++; if (!got || issued.size() < b + 2) begin errs++; $display("FAIL tie_done: got=%b reads=%0d want 1/2", got, issued.size() - b); end
    else begin
      checks++; if (issued[b] !== 14'h0010 || issued[b+1] !== 14'h2020) begin errs++; $display("FAIL tie_order: %h,%h want 0010,2020", issued[b], issued[b+1]); end
    end
    checks++; if (scr_data !== f(14'h0010) || obj_data !== f(14'h2020)) begin errs++; $display("FAIL tie_data: scr=%h obj=%h want %h/%h", scr_data, obj_data, f(14'h0010), f(14'h2020)); end
    scr_addr = 13'h0011; obj_addr = 13'h0021;
    wait_ok(1'b1, 1'b1, got);
    checks++; if (!got || issued.size() < b + 4) begin errs++; $display("FAIL tie2_done: got=%b reads=%0d want 1/4", got, issued.size() - b); end
    else begin
      checks++; if (issued[b+2] !== 14'h0011 || issued[b+3] !== 14'h2021) begin errs++; $display("FAIL tie2_order: %h,%h want 0011,2021", issued[b+2], issued[b+3]); end
    end
  endtask

  task automatic test_addr_change();
    bit got;
    rsp_en = 1'b0;
    do_reset();
    scr_cs = 1'b1; scr_addr = 13'h0100;
    wait_cs(got);
    @(negedge clk);
    scr_addr = 13'h0101;
    @(negedge clk);
    m_ok = 1'b1; m_data = 32'h1111_0100;
    @(negedge clk);
    m_ok = 1'b0;
    checks++; if (scr_ok !== 1'b0 || mem_cs !== 1'b0) begin errs++; $display("FAIL chg_nofalsehit: scr_ok=%b mem_cs=%b want 0/0", scr_ok, mem_cs); end
    @(negedge clk);
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 14'h0101) begin errs++; $display("FAIL chg_refetch: mem_cs=%b mem_addr=%h want 1/0101", mem_cs, mem_addr); end
    scr_addr = 13'h0100;
    #1;
    checks++; if (scr_ok !== 1'b1 || scr_data !== 32'h1111_0100) begin errs++; $display("FAIL chg_oldtag: scr_ok=%b data=%h want 1/11110100", scr_ok, scr_data); end
    scr_addr = 13'h0101;
    #1;
    checks++; if (scr_ok !== 1'b0) begin errs++; $display("FAIL chg_newmiss: scr_ok=%b want 0", scr_ok); end
    @(negedge clk);
    m_ok = 1'b1; m_data = 32'h2222_0101;
    @(negedge clk);
    m_ok = 1'b0;
    checks++; if (scr_ok !== 1'b1 || scr_data !== 32'h2222_0101) begin errs++; $display("FAIL chg_final: scr_ok=%b data=%h want 1/22220101", scr_ok, scr_data); end
  endtask

  task automatic test_timeout();
    bit got, bad;
    int n;
    rsp_en = 1'b0;
    do_reset();
    obj_cs = 1'b1; obj_addr = 13'h0055;
    wait_cs(got);
    n = 0; bad = 1'b0;
    while (mem_cs && n < 50) begin
      n++;
      if (timeout !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (n != TO || bad) begin errs++; $display("FAIL to_len: mem_cs high %0d cycles early_pulse=%b want %0d/0", n, bad, TO); end
    checks++; if (timeout !== 1'b1 || obj_ok !== 1'b0) begin errs++; $display("FAIL to_pulse: timeout=%b obj_ok=%b want 1/0", timeout, obj_ok); end
    @(negedge clk);
    checks++; if (timeout !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 14'h2055 || obj_ok !== 1'b0) begin errs++; $display("FAIL to_retry: to=%b cs=%b addr=%h ok=%b want 0/1/2055/0", timeout, mem_cs, mem_addr, obj_ok); end
  endtask

  task automatic test_flush();
    bit got;
    int b;
    rsp_en = 1'b1; lat = 1;
    do_reset();
    scr_cs = 1'b1; scr_addr = 13'h0A00; obj_cs = 1'b1; obj_addr = 13'h0B00;
    wait_ok(1'b1, 1'b1, got);
    b = issued.size();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (!got || scr_ok !== 1'b0 || obj_ok !== 1'b0) begin errs++; $display("FAIL flush_drop: got=%b scr_ok=%b obj_ok=%b want 1/0/0", got, scr_ok, obj_ok); end
    wait_ok(1'b1, 1'b1, got);
    checks++; if (!got || issued.size() != b + 2) begin errs++; $display("FAIL flush_refetch: got=%b reads=%0d want 1/2", got, issued.size() - b); end
    rsp_en = 1'b0; m_ok = 1'b0;
    obj_addr = 13'h0777;
    wait_cs(got);
    checks++; if (!got || mem_addr !== 14'h2777) begin errs++; $display("FAIL flush_objissue: got=%b mem_addr=%h want 2777", got, mem_addr); end
    @(negedge clk);
    m_ok = 1'b1; m_data = 32'hCAFE_F00D; flush = 1'b1;
    @(negedge clk);
    m_ok = 1'b0; flush = 1'b0;
    checks++; if (obj_ok !== 1'b1 || obj_data !== 32'hCAFE_F00D || scr_ok !== 1'b0) begin errs++; $display("FAIL flush_coincide: obj_ok=%b obj=%h scr_ok=%b want 1/cafef00d/0", obj_ok, obj_data, scr_ok); end
  endtask

  task automatic test_rst_mid();
    bit got;
    rsp_en = 1'b0;
    do_reset();
    scr_cs = 1'b1; scr_addr = 13'h0200;
    wait_cs(got);
    rst = 1'b1; scr_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (!got || mem_cs !== 1'b0) begin errs++; $display("FAIL rstmid_cs: got=%b mem_cs=%b want 1/0", got, mem_cs); end
    @(negedge clk);
    m_ok = 1'b1; m_data = 32'h5555_AAAA;
    @(negedge clk);
    m_ok = 1'b0;
    scr_cs = 1'b1; obj_cs = 1'b1; obj_addr = 13'h0000;
    #1;
    checks++; if (mem_cs !== 1'b0 || scr_ok !== 1'b0 || obj_ok !== 1'b0) begin errs++; $display("FAIL rstmid_late: cs=%b scr_ok=%b obj_ok=%b want 0/0/0", mem_cs, scr_ok, obj_ok); end
    scr_cs = 1'b0; obj_cs = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] sp [4] = '{13'h0010, 13'h0011, 13'h1FFF, 13'h0000};
    logic [AW-1:0] op [4] = '{13'h0020, 13'h0000, 13'h1FFF, 13'h0ABC};
    logic [AW:0]   held;
    bit            exp_s, exp_o, prev, got;
    rsp_en = 1'b1; lat = 2;
    do_reset();
    prev = 1'b0; held = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      exp_s = scr_cs && mv[0] && mt[0] == scr_addr;
      exp_o = obj_cs && mv[1] && mt[1] == obj_addr;
      checks++; if (scr_ok !== exp_s) begin errs++; $display("FAIL rnd_scr_ok @%0d: %b want %b", i, scr_ok, exp_s); end
      checks++; if (obj_ok !== exp_o) begin errs++; $display("FAIL rnd_obj_ok @%0d: %b want %b", i, obj_ok, exp_o); end
      if (exp_s) begin checks++; if (scr_data !== f({1'b0, scr_addr})) begin errs++; $display("FAIL rnd_scr_data @%0d: %h want %h", i, scr_data, f({1'b0, scr_addr})); end end
      if (exp_o) begin checks++; if (obj_data !== f({1'b1, obj_addr})) begin errs++; $display("FAIL rnd_obj_data @%0d: %h want %h", i, obj_data, f({1'b1, obj_addr})); end end
      if (mem_cs && prev) begin checks++; if (mem_addr !== held) begin errs++; $display("FAIL rnd_addr_stable @%0d: %h want %h", i, mem_addr, held); end end
      checks++; if (timeout !== 1'b0) begin errs++; $display("FAIL rnd_timeout @%0d: %b want 0", i, timeout); end
      prev = mem_cs; held = mem_addr;
      scr_cs = $urandom_range(0, 9) < 8;
      obj_cs = $urandom_range(0, 9) < 8;
      if ($urandom_range(0, 4) == 0) scr_addr = sp[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) obj_addr = op[$urandom_range(0, 3)];
      flush = $urandom_range(0, 31) == 0;
      if (!mem_cs) lat = $urandom_range(0, 5);
    end
    flush = 1'b0; scr_cs = 1'b1; obj_cs = 1'b1;
    wait_ok(1'b1, 1'b1, got);
    checks++; if (!got) begin errs++; $display("FAIL rnd_live: scr_ok=%b obj_ok=%b want 1/1", scr_ok, obj_ok); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_addr_change();
    test_timeout();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/jtkicker_gfx_arb.md
Name: jtkicker_gfx_arb

Overview:
Shares one SDRAM graphics ROM read port between the scroll tile fetcher and the object fetcher of the video block. Each requester sees a private one-word buffer, tagged with its address, behind the usual cs/addr/data/ok interface. The arbiter issues one SDRAM read at a time and grants round-robin when both requesters miss. It sits between the scroll/object engines and the SDRAM controller's single 32-bit slot.

Parameters:
AW, 13, requester word-address width; memory address is AW+1 bits, MSB selects region (0 scroll, 1 object)
DW, 32, data width
TIMEOUT, 255, cycles to wait for mem_ok before aborting a read; 0 disables the timeout

Ports:
clk  in  1  system clock (48 MHz); all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  one-cycle pulse; invalidates both buffers
scr_cs  in  1  scroll requester active
scr_addr  in  AW  scroll word address
scr_data  out  DW  scroll buffered word
scr_ok  out  1  scr_data valid for current scr_addr
obj_cs  in  1  object requester active
obj_addr  in  AW  object word address
obj_data  out  DW  object buffered word
obj_ok  out  1  obj_data valid for current obj_addr
mem_cs  out  1  SDRAM read request, held until mem_ok or timeout
mem_addr  out  AW+1  {region, addr}
mem_data  in  DW  SDRAM read data
mem_ok  in  1  mem_data valid; sampled only while mem_cs=1
timeout  out  1  one-cycle pulse when a read is aborted

Behaviour:
- Per requester X: registers tagX[AW-1:0], bufX[DW-1:0], validX.
- hitX = validX && tagX==X_addr. X_ok = X_cs && hitX, combinational. X_data = bufX.
- missX = X_cs && !hitX.
- Reset: state IDLE, mem_cs=0, mem_addr=0, valid bits 0, bufs 0, tags 0, last_grant=obj (scroll wins the first tie), timeout=0, counter 0.
- FSM:
  - IDLE: if neither requester misses, stay. If exactly one misses, grant it. If both miss, grant the one opposite last_grant.
  - On grant (registered): mem_cs<=1, mem_addr<={sel, X_addr}, latch issued address in itag, last_grant<=sel, counter<=0, go to WAIT.
  - WAIT: mem_cs and mem_addr are held stable. If mem_ok, then buf[sel]<=mem_data, tag[sel]<=itag, valid[sel]<=1, mem_cs<=0, go to IDLE.
  - WAIT, no mem_ok: if TIMEOUT!=0 and counter==TIMEOUT-1, then mem_cs<=0, timeout<=1 for one cycle, go to IDLE; buffer and valid are unchanged. Otherwise counter++.
- Latency:
  - Miss seen in IDLE at cycle n gives mem_cs=1 from cycle n+1.
  - mem_ok at cycle m gives X_ok=1 from cycle m+1, if the address is unchanged.
  - IDLE takes at least one cycle between reads, so back-to-back grants are 2+mem latency apart.
- Requester address change during WAIT:
  - The read completes and is stored under the issued tag, so no false hit.
  - The new address misses and is re-fetched in a later IDLE cycle.
  - Until then the buffer holds the old word and X_ok stays 0.
- X_cs low: X_ok=0; the buffer is retained. Re-asserting X_cs with the same address hits immediately with no SDRAM access.
- flush:
  - Clears both valid bits at the next edge.
  - If it coincides with the mem_ok capture, the capture wins for that requester: its valid is set and the other requester's valid is cleared.
  - flush in WAIT does not abort the read.
- mem_ok while mem_cs=0 is ignored.
- Reset mid-read: mem_cs drops at the next edge and all valid bits clear. A late mem_ok is ignored.
- Counter width: ceil(log2(TIMEOUT+1)). With TIMEOUT=0 the counter is unused and WAIT waits indefinitely.

Test Plan:
- Reset then scr_cs=1, scr_addr=0x0123, mem_ok 4 cycles after mem_cs → mem_addr=0x0123 (MSB 0), scr_ok=1 one cycle after mem_ok, scr_data equals mem_data 0xDEADBEEF; holding the address causes no new mem_cs.
- Both miss simultaneously after reset (scr 0x0010, obj 0x0020) → first mem_addr=0x0010, second mem_addr=0x2020; obj_ok follows the second mem_ok; a further tie grants scroll first.
- scr_addr changes 0x0100→0x0101 during WAIT → stored tag 0x0100, scr_ok stays 0, a second read with mem_addr=0x0101 is issued, then scr_ok=1.
- TIMEOUT=8, mem_ok never asserted → mem_cs high for exactly 8 cycles, one timeout pulse, FSM back in IDLE, retry issued next cycle, valid still 0.
- flush pulse with both buffers valid → scr_ok and obj_ok drop the next cycle and both are refetched; flush coincident with obj mem_ok → obj_ok=1 and scr_ok=0.
- rst asserted during WAIT, mem_ok arrives 2 cycles later → mem_cs=0 after the reset edge, mem_ok ignored, all ok outputs 0.
